// File: rtl/counter7sd_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter7sd_run_ctrl
// Purpose  : Run-control sequencer for the Counter7SD seven-segment counter.
//            Debounces three raw push-buttons and turns their presses into
//            the counter's pause / reverse controls. It handles run/stop,
//            single-step, and direction change. A direction change while
//            running passes through a paused gap, so the counter never
//            reverses on a live count.
// Ports    : clock    - system clock, rising edge
//            reset    - synchronous, active-high
//            btn_run  - raw button, toggles run/stop
//            btn_step - raw button, single step while stopped
//            btn_dir  - raw button, direction change request
//            pause    - 1 = counter holds
//            reverse  - 1 = counter counts down
//            busy     - 1 while stepping or turning
//            state    - FSM state: 00 stopped, 01 running, 10 stepping,
//                       11 turning
// Revision : 1.0 - initial release
// ============================================================================
module counter7sd_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 6,
    parameter int GAP_CYCLES      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_dir,
    output logic       pause,
    output logic       reverse,
    output logic       busy,
    output logic [1:0] state
);

    // One shared counter width, sized for the largest cycle parameter.
    localparam int c_MAX_SG = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int c_MAX_P  = (DEBOUNCE_CYCLES > c_MAX_SG) ? DEBOUNCE_CYCLES : c_MAX_SG;
    localparam int c_CNT_W  = $clog2(c_MAX_P) + 1;

    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STEP_LOAD = c_CNT_W'(STEP_CYCLES);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    localparam logic [1:0] c_ST_STOPPED  = 2'b00;
    localparam logic [1:0] c_ST_RUNNING  = 2'b01;
    localparam logic [1:0] c_ST_STEPPING = 2'b10;
    localparam logic [1:0] c_ST_TURNING  = 2'b11;

    logic [2:0] w_btn_raw;
    logic [2:0] w_evt;
    logic       w_run_evt;
    logic       w_step_evt;
    logic       w_dir_evt;

    assign w_btn_raw = {btn_dir, btn_step, btn_run};

    // Per-button input path: 2-flop synchroniser, debounce, press detect.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_level_d;
        logic               r_evt;
        logic [c_CNT_W-1:0] r_db_cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_evt     <= 1'b0;
                r_db_cnt  <= '0;
            end else begin
                r_sync1   <= w_btn_raw[gi];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                // Press pulse is derived from the registered level so the
                // FSM sees it one edge after the debounced level rises.
                r_evt     <= r_level & ~r_level_d;
                if (r_sync2 == r_level) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_level  <= ~r_level;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_ONE;
                end
            end
        end

        assign w_evt[gi] = r_evt;
    end

    assign w_run_evt  = w_evt[0];
    assign w_step_evt = w_evt[1];
    assign w_dir_evt  = w_evt[2];

    logic [1:0]         r_state;
    logic               r_pause;
    logic               r_reverse;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_step_cnt;
    logic [c_CNT_W-1:0] r_gap_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_STOPPED;
            r_pause    <= 1'b1;
            r_reverse  <= 1'b0;
            r_busy     <= 1'b0;
            r_step_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_STOPPED: begin
                    if (w_run_evt) begin
                        r_state <= c_ST_RUNNING;
                        r_pause <= 1'b0;
                    end else if (w_dir_evt) begin
                        // Counter is held, so the direction can flip directly.
                        r_reverse <= ~r_reverse;
                    end else if (w_step_evt) begin
                        r_state    <= c_ST_STEPPING;
                        r_pause    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_step_cnt <= c_STEP_LOAD;
                    end
                end
                c_ST_RUNNING: begin
                    if (w_run_evt) begin
                        r_state <= c_ST_STOPPED;
                        r_pause <= 1'b1;
                    end else if (w_dir_evt) begin
                        r_state   <= c_ST_TURNING;
                        r_pause   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_gap_cnt <= c_GAP_LOAD;
                    end
                end
                c_ST_STEPPING: begin
                    // Events arriving mid-step are discarded.
                    if (r_step_cnt == c_ONE) begin
                        r_state <= c_ST_STOPPED;
                        r_pause <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_step_cnt <= r_step_cnt - c_ONE;
                    end
                end
                default: begin // c_ST_TURNING
                    if (w_run_evt) begin
                        // Stop request still honours the pending turn.
                        r_state   <= c_ST_STOPPED;
                        r_reverse <= ~r_reverse;
                        r_busy    <= 1'b0;
                    end else if (r_gap_cnt == c_ONE) begin
                        r_state   <= c_ST_RUNNING;
                        r_pause   <= 1'b0;
                        r_reverse <= ~r_reverse;
                        r_busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_ONE;
                    end
                end
            endcase
        end
    end

    assign state   = r_state;
    assign pause   = r_pause;
    assign reverse = r_reverse;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_counter7sd_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter7sd_run_ctrl
// Purpose  : Directed self-checking bench for counter7sd_run_ctrl.
//            Observed vector is {state, pause, reverse, busy}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter7sd_run_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_dir = 1'b0;
    logic       pause;
    logic       reverse;
    logic       busy;
    logic [1:0] state;
    logic [4:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    counter7sd_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (6),
        .GAP_CYCLES     (3)
    ) dut (
        .clock   (clk),
        .reset   (rst),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .btn_dir (btn_dir),
        .pause   (pause),
        .reverse (reverse),
        .busy    (busy),
        .state   (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, pause, reverse, busy};

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full press: 6 cycles high (event reaches FSM at edge 8), then
    // 10 cycles low so the release is fully debounced.
    task automatic press(input int which);
        case (which)
            0: btn_run  = 1'b1;
            1: btn_step = 1'b1;
            default: btn_dir = 1'b1;
        endcase
        repeat (6) tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_dir  = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_tests++;
            if (obs !== 5'b00_1_0_0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %b want %b", k, obs, 5'b00_1_0_0);
            end
        end
    endtask

    task automatic test_run();
        btn_run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) begin
                n_tests++;
                if (obs !== 5'b00_1_0_0) begin
                    n_fail++;
                    $display("FAIL run_latency_early: got %b want %b", obs, 5'b00_1_0_0);
                end
            end
            if (k == 8) begin
                n_tests++;
                if (obs !== 5'b01_0_0_0) begin
                    n_fail++;
                    $display("FAIL run_start: got %b want %b", obs, 5'b01_0_0_0);
                end
            end
        end
        btn_run = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (obs !== 5'b01_0_0_0) begin
            n_fail++;
            $display("FAIL run_release_noevt: got %b want %b", obs, 5'b01_0_0_0);
        end
        btn_run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6) btn_run = 1'b0;
            if (k == 7) begin
                n_tests++;
                if (obs !== 5'b01_0_0_0) begin
                    n_fail++;
                    $display("FAIL run_stop_early: got %b want %b", obs, 5'b01_0_0_0);
                end
            end
            if (k == 8) begin
                n_tests++;
                if (obs !== 5'b00_1_0_0) begin
                    n_fail++;
                    $display("FAIL run_stop: got %b want %b", obs, 5'b00_1_0_0);
                end
            end
        end
    endtask

    task automatic test_step();
        logic [4:0] exp;
        int low_cnt;
        low_cnt  = 0;
        btn_step = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 4) btn_run = 1'b1;   // run event lands mid-step
            if (k == 5) btn_step = 1'b0;
            if (k == 10) btn_run = 1'b0;
            if (pause === 1'b0) low_cnt++;
            exp = (k >= 8 && k <= 13) ? 5'b10_0_0_1 : 5'b00_1_0_0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL step_seq cyc%0d: got %b want %b", k, obs, exp);
            end
        end
        n_tests++;
        if (low_cnt != 6) begin
            n_fail++;
            $display("FAIL step_pause_len: got %0d want 6", low_cnt);
        end
    endtask

    task automatic test_turn();
        logic [4:0] exp;
        press(0);
        n_tests++;
        if (obs !== 5'b01_0_0_0) begin
            n_fail++;
            $display("FAIL turn_setup_run: got %b want %b", obs, 5'b01_0_0_0);
        end
        btn_dir = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6) btn_dir = 1'b0;
            if (k < 8)       exp = 5'b01_0_0_0;
            else if (k < 11) exp = 5'b11_1_0_1;
            else             exp = 5'b01_0_1_0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL turn_seq cyc%0d: got %b want %b", k, obs, exp);
            end
        end
        press(0);
        n_tests++;
        if (obs !== 5'b00_1_1_0) begin
            n_fail++;
            $display("FAIL turn_stop: got %b want %b", obs, 5'b00_1_1_0);
        end
        btn_dir = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6) btn_dir = 1'b0;
            exp = (k < 8) ? 5'b00_1_1_0 : 5'b00_1_0_0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL dir_stopped cyc%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_turn_run_abort();
        logic [4:0] exp;
        press(0);
        n_tests++;
        if (obs !== 5'b01_0_0_0) begin
            n_fail++;
            $display("FAIL abort_setup_run: got %b want %b", obs, 5'b01_0_0_0);
        end
        btn_dir = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) btn_run = 1'b1;   // run event one edge after dir event
            if (k == 6) btn_dir = 1'b0;
            if (k == 7) btn_run = 1'b0;
            if (k < 8)       exp = 5'b01_0_0_0;
            else if (k == 8) exp = 5'b11_1_0_1;
            else             exp = 5'b00_1_1_0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL turn_run_abort cyc%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_glitch_and_simul();
        logic [4:0] exp;
        btn_run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) btn_run = 1'b0;
            n_tests++;
            if (obs !== 5'b00_1_1_0) begin
                n_fail++;
                $display("FAIL glitch cyc%0d: got %b want %b", k, obs, 5'b00_1_1_0);
            end
        end
        btn_run = 1'b1;
        btn_dir = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6) begin
                btn_run = 1'b0;
                btn_dir = 1'b0;
            end
            exp = (k < 8) ? 5'b00_1_1_0 : 5'b01_0_1_0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL simul_run_dir cyc%0d: got %b want %b", k, obs, exp);
            end
        end
        press(0);
        n_tests++;
        if (obs !== 5'b00_1_1_0) begin
            n_fail++;
            $display("FAIL simul_stop: got %b want %b", obs, 5'b00_1_1_0);
        end
    endtask

    task automatic test_reset_abort();
        btn_step = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 5) btn_step = 1'b0;
            if (k >= 8) begin
                n_tests++;
                if (obs !== 5'b10_0_1_1) begin
                    n_fail++;
                    $display("FAIL rst_step_pre cyc%0d: got %b want %b", k, obs, 5'b10_0_1_1);
                end
            end
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (obs !== 5'b00_1_0_0) begin
            n_fail++;
            $display("FAIL rst_mid_step: got %b want %b", obs, 5'b00_1_0_0);
        end
        rst = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (obs !== 5'b00_1_0_0) begin
            n_fail++;
            $display("FAIL rst_step_after: got %b want %b", obs, 5'b00_1_0_0);
        end
        press(0);
        n_tests++;
        if (obs !== 5'b01_0_0_0) begin
            n_fail++;
            $display("FAIL rst_turn_setup: got %b want %b", obs, 5'b01_0_0_0);
        end
        btn_dir = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 6) btn_dir = 1'b0;
            if (k >= 8) begin
                n_tests++;
                if (obs !== 5'b11_1_0_1) begin
                    n_fail++;
                    $display("FAIL rst_turn_pre cyc%0d: got %b want %b", k, obs, 5'b11_1_0_1);
                end
            end
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (obs !== 5'b00_1_0_0) begin
            n_fail++;
            $display("FAIL rst_mid_turn: got %b want %b", obs, 5'b00_1_0_0);
        end
        rst = 1'b0;
        repeat (12) tick();
        n_tests++;
        if (obs !== 5'b00_1_0_0) begin
            n_fail++;
            $display("FAIL rst_turn_after: got %b want %b", obs, 5'b00_1_0_0);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_turn();
        test_turn_run_abort();
        test_glitch_and_simul();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
